// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states, exception causes.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [1:0] EXC_MISAL = 2'b01;
  localparam logic [1:0] EXC_ILL   = 2'b10;
  localparam logic [1:0] EXC_TMO   = 2'b11;
endpackage

// File: rtl/lsu_mem_if.sv
// Request/acknowledge bus between the load/store unit (master) and data memory (slave).
interface lsu_mem_if #(parameter int XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: request decode (be/wdata/misalign/illegal) on live inputs,
// load extraction on the funct3/offset latched for the outstanding access.
module lsu_align
  import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      req_f3,
    input  logic [1:0]      req_lo,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [XLEN-1:0] store_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic            misal,
    output logic            illegal,
    input  logic [2:0]      ld_f3,
    input  logic [1:0]      ld_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_val
);
    logic [XLEN-1:0] lane;

    always_comb begin
        illegal = (memread & memwrite) | (req_f3 == 3'b011) | (req_f3[2:1] == 2'b11)
                | (memwrite & req_f3[2]);
        misal = 1'b0;
        be    = 4'b1111;
        wdata = store_data;
        // Size comes from funct3[1:0]; the unsigned variants share the signed lanes.
        case (req_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << req_lo;
                wdata = {(XLEN/8){store_data[7:0]}};
            end
            2'b01: begin
                misal = req_lo[0];
                be    = 4'b0011 << req_lo;
                wdata = {(XLEN/16){store_data[15:0]}};
            end
            default: begin
                misal = |req_lo;
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        lane = rdata >> {ld_lo, 3'b000};
        case (ld_f3)
            F3_B:    load_val = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_H:    load_val = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_BU:   load_val = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_HU:   load_val = {{(XLEN-16){1'b0}}, lane[15:0]};
            F3_W:    load_val = lane;
            default: load_val = lane;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: turns one EX/MEM memory request into a req/ack transaction,
// stalls the pipeline until it completes, and reports misaligned/illegal/timed-out accesses.
module lsu_ctrl
  import lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] store_data,
    lsu_mem_if.master       mem,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] load_data,
    output logic            exc_valid,
    output logic [1:0]      exc_cause
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]      state;
    logic [CW-1:0]   tmo_cnt;
    logic [2:0]      ld_f3;
    logic [1:0]      ld_lo;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] load_val;
    logic            misal;
    logic            illegal;
    logic            start;

    lsu_align #(.XLEN(XLEN)) u_align (
        .req_f3     (funct3),
        .req_lo     (address[1:0]),
        .memread    (memread),
        .memwrite   (memwrite),
        .store_data (store_data),
        .be         (be),
        .wdata      (wdata),
        .misal      (misal),
        .illegal    (illegal),
        .ld_f3      (ld_f3),
        .ld_lo      (ld_lo),
        .rdata      (mem.mem_rdata),
        .load_val   (load_val)
    );

    assign start = in_valid & (memread | memwrite);
    // DONE/ERR drop stall so the pipeline advances exactly once per access.
    assign stall = ((state == ST_IDLE) & start) | (state == ST_REQ);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_IDLE;
            tmo_cnt       <= '0;
            ld_f3         <= '0;
            ld_lo         <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            out_valid     <= 1'b0;
            load_data     <= '0;
            exc_valid     <= 1'b0;
            exc_cause     <= '0;
        end else begin
            out_valid <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (illegal | misal) begin
                            state     <= ST_ERR;
                            exc_valid <= 1'b1;
                            exc_cause <= illegal ? EXC_ILL : EXC_MISAL;
                        end else begin
                            state         <= ST_REQ;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= memwrite;
                            mem.mem_addr  <= {address[XLEN-1:2], 2'b00};
                            mem.mem_be    <= be;
                            mem.mem_wdata <= memwrite ? wdata : '0;
                            ld_f3         <= funct3;
                            ld_lo         <= address[1:0];
                            tmo_cnt       <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ack) begin
                        state       <= ST_DONE;
                        mem.mem_req <= 1'b0;
                        out_valid   <= 1'b1;
                        load_data   <= mem.mem_we ? '0 : load_val;
                        tmo_cnt     <= '0;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        state       <= ST_ERR;
                        mem.mem_req <= 1'b0;
                        exc_valid   <= 1'b1;
                        exc_cause   <= EXC_TMO;
                        tmo_cnt     <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
